// File: rtl/serial_tx_buffer.sv
// -----------------------------------------------------------------------------
// serial_tx_buffer
//
// Byte FIFO between the debug message generator and the AVR serial TX port.
// The producer can write a whole debug line in a burst. Bytes are then sent
// one at a time, paced by the AVR tx_busy handshake. The block reports the
// FIFO level and a sticky flag that is set when a byte is dropped.
//
// Parameters
//   DEPTH      FIFO entries. Must be a power of 2 and >= 4.
//   ADDR_BITS  Pointer width. Derived from DEPTH; do not override.
//
// Ports
//   clk         in   1            system clock
//   rst         in   1            synchronous, active-high reset
//   in_data     in   8            byte from producer
//   in_valid    in   1            1-cycle write strobe
//   in_busy     out  1            FIFO full; producer must not strobe
//   out_data    out  8            byte to AVR; held until the next launch
//   out_valid   out  1            1-cycle send strobe to AVR
//   out_busy    in   1            AVR tx_busy
//   level       out  ADDR_BITS+1  current occupancy, 0..DEPTH
//   overflow    out  1            sticky: a write was dropped while full
//   high_water  out  ADDR_BITS+1  max level since reset (stats option)
//   drop_cnt    out  16           dropped-byte count, saturating (stats option)
//
// Configuration
//   TX_BUFFER_STATS_EN  When defined, the high_water and drop_cnt registers
//                       are built. When undefined, both ports are tied to 0.
// -----------------------------------------------------------------------------
module serial_tx_buffer #(
  parameter  int DEPTH     = 32,
  localparam int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_busy,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_busy,
  output logic [ADDR_BITS:0]   level,
  output logic                 overflow,
  output logic [ADDR_BITS:0]   high_water,
  output logic [15:0]          drop_cnt
);

  localparam logic [ADDR_BITS:0] FULL_LEVEL = (ADDR_BITS + 1)'(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  logic [7:0]           mem [DEPTH];

  state_e               state_q,    state_d;
  logic [ADDR_BITS-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_BITS:0]   level_q,    level_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overflow_q, overflow_d;

  logic                 wr_en;
  logic                 drop;
  logic                 can_launch;
  logic                 launch;

  // The full flag comes from the registered level only. It never depends on
  // in_valid, so the producer does not see a combinational loop.
  assign in_busy = (level_q == FULL_LEVEL);
  assign wr_en   = in_valid && !in_busy;
  assign drop    = in_valid &&  in_busy;

  // A launch uses the level sampled before the edge. A byte written into an
  // empty FIFO therefore waits one cycle; there is no bypass path.
  assign can_launch = (state_q == ST_IDLE) && (level_q != '0) && !out_busy;

  // ---------------------------------------------------------------------------
  // Read FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: next-state logic
  // HOLD lasts exactly one cycle and ignores out_busy. This gives the AVR
  // time to raise tx_busy after a strobe.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first, so that no path
    // leaves it unassigned and a latch is never inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (can_launch) state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read FSM: output logic
  // out_data keeps its value between launches.
  // ---------------------------------------------------------------------------
  always_comb begin
    launch      = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (can_launch) begin
      launch      = 1'b1;
      out_valid_d = 1'b1;
      out_data_d  = mem[rd_ptr_q];
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer, level and flag next-state logic
  // The pointers wrap modulo DEPTH. Because DEPTH is a power of 2, this is
  // plain ADDR_BITS-bit overflow. Full and empty are told apart by level, not
  // by an extra wrap bit. A write that is dropped while full does not stop a
  // launch on the same edge, so level falls from DEPTH to DEPTH-1.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q || drop;

    if (wr_en)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (launch) rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({wr_en, launch})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state is assigned with non-blocking (<=) only. All
      // registers then update together at the edge, and the result does not
      // depend on the order of the statements or of the processes.
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset. Clearing the pointers and the level
  // is enough to make the old contents unreachable. Leaving the array without
  // a reset also lets it map onto RAM or an unreset register file.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= in_data;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign overflow  = overflow_q;

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef TX_BUFFER_STATS_EN
  logic [ADDR_BITS:0] high_water_q;
  logic [15:0]        drop_cnt_q;

  // high_water follows the registered level. It therefore lags the level by
  // one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      high_water_q <= '0;
      drop_cnt_q   <= 16'h0000;
    end else begin
      if (level_q > high_water_q) high_water_q <= level_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign high_water = high_water_q;
  assign drop_cnt   = drop_cnt_q;
`else
  assign high_water = '0;
  assign drop_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_serial_tx_buffer.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_buffer
//
// Self-checking bench for serial_tx_buffer. The reference model is a byte
// queue together with a few scalar flags:
//   - A launch happens when the queue was non-empty before the edge, out_busy
//     is low, and the previous cycle was not itself a launch.
//   - A write that arrives while the queue holds DEPTH bytes is dropped.
// -----------------------------------------------------------------------------
module tb_serial_tx_buffer;

  localparam int DEPTH = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_busy;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_busy;
  logic [LW-1:0] level;
  logic          overflow;
  logic [LW-1:0] high_water;
  logic [15:0]   drop_cnt;

  int tests_run = 0;
  int fails     = 0;

  // Reference model state
  logic [7:0] m_q[$];
  bit         m_prev_launch;
  bit         m_ovf;
  int         m_drop;
  int         m_hw;
  logic [7:0] m_out_data;
  bit         m_out_valid;

  serial_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_busy    (in_busy),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_busy   (out_busy),
    .level      (level),
    .overflow   (overflow),
    .high_water (high_water),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required <2ms", $time);
    $fatal(1);
  end

  // Expected statistics ports for the current build.
  function automatic int exp_hw();
`ifdef TX_BUFFER_STATS_EN
    return m_hw;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_drop();
`ifdef TX_BUFFER_STATS_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  // Reset the DUT and the model for one clock edge.
  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    out_busy = 1'b0;
    @(posedge clk);
    m_q.delete();
    m_prev_launch = 0;
    m_ovf         = 0;
    m_drop        = 0;
    m_hw          = 0;
    m_out_data    = 8'h00;
    m_out_valid   = 0;
    #1;
    rst = 1'b0;
  endtask

  // Drive one cycle, advance the model over the edge, and return at edge+1.
  task automatic tick(input bit v, input logic [7:0] d, input bit b);
    int lvl;
    bit go;
    in_valid = v;
    in_data  = d;
    out_busy = b;
    @(posedge clk);
    lvl = m_q.size();
    go  = !m_prev_launch && (lvl != 0) && !b;
    if (v) begin
      if (lvl == DEPTH) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end else begin
        m_q.push_back(d);
      end
    end
    if (go) m_out_data = m_q.pop_front();
    m_out_valid   = go;
    m_prev_launch = go;
    if (lvl > m_hw) m_hw = lvl;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || level !== '0 || in_busy !== 1'b0 ||
        overflow !== 1'b0 || high_water !== '0 || drop_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: got ov=%b od=%h lvl=%0d ib=%b ovf=%b hw=%0d dc=%0d, required all zero",
               out_valid, out_data, level, in_busy, overflow, high_water, drop_cnt);
    end
  endtask

  // Test 1: a single byte.
  task automatic test_single();
    do_reset();
    tick(1, 8'h41, 0);
    tests_run++;
    if (level !== LW'(1) || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_after_write: lvl=%0d ov=%b, required lvl=1 ov=0", level, out_valid);
    end
    tick(0, 8'h00, 0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h41 || level !== '0) begin
      fails++;
      $display("FAIL single_launch: ov=%b od=%h lvl=%0d, required ov=1 od=41 lvl=0", out_valid, out_data, level);
    end
    tick(0, 8'h00, 0);
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 8'h41) begin
      fails++;
      $display("FAIL single_one_cycle: ov=%b od=%h, required ov=0 od=41", out_valid, out_data);
    end
  endtask

  // Test 2: a 24-byte debug line written in a burst, then drained.
  task automatic test_burst_line();
    string s;
    int    n;
    bit    prev_v;
    bit    bad_order;
    bit    bad_gap;
    bit    early;
    s = "AIT: t=0001 lvl=07 ok!\r\n";
    do_reset();
    early = 0;
    for (int i = 0; i < 24; i++) begin
      tick(1, s[i], 1);
      if (out_valid !== 1'b0) early = 1;
    end
    tests_run++;
    if (level !== LW'(24) || in_busy !== 1'b0 || early) begin
      fails++;
      $display("FAIL burst_fill: lvl=%0d ib=%b early_strobe=%b, required lvl=24 ib=0 early_strobe=0",
               level, in_busy, early);
    end
    n = 0; prev_v = 0; bad_order = 0; bad_gap = 0;
    for (int c = 0; c < 60; c++) begin
      tick(0, 8'h00, 0);
      if (out_valid === 1'b1) begin
        if (prev_v) bad_gap = 1;
        if (n >= 24 || out_data !== s[n]) bad_order = 1;
        n++;
      end
      prev_v = (out_valid === 1'b1);
    end
    tests_run++;
    if (n != 24 || bad_order || bad_gap || level !== '0) begin
      fails++;
      $display("FAIL burst_drain: strobes=%0d order_err=%b gap_err=%b lvl=%0d, required 24 0 0 0",
               n, bad_order, bad_gap, level);
    end
  endtask

  // Test 3: write DEPTH+3 bytes while the AVR is busy, then drain.
  task automatic test_overflow();
    logic [7:0] exp_b[DEPTH+3];
    int         n;
    bit         bad;
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      exp_b[i] = 8'($urandom);
      tick(1, exp_b[i], 1);
      if (i == DEPTH - 1) begin
        tests_run++;
        if (in_busy !== 1'b1 || level !== LW'(DEPTH) || overflow !== 1'b0) begin
          fails++;
          $display("FAIL ovf_full: ib=%b lvl=%0d ovf=%b, required ib=1 lvl=%0d ovf=0",
                   in_busy, level, overflow, DEPTH);
        end
      end
    end
    tests_run++;
    if (overflow !== 1'b1 || level !== LW'(DEPTH) || drop_cnt !== 16'(exp_drop()) ||
        high_water !== LW'(exp_hw())) begin
      fails++;
      $display("FAIL ovf_status: ovf=%b lvl=%0d dc=%0d hw=%0d, required ovf=1 lvl=%0d dc=%0d hw=%0d",
               overflow, level, drop_cnt, high_water, DEPTH, exp_drop(), exp_hw());
    end
`ifdef TX_BUFFER_STATS_EN
    tests_run++;
    if (drop_cnt !== 16'd3 || high_water !== LW'(DEPTH)) begin
      fails++;
      $display("FAIL ovf_stats: dc=%0d hw=%0d, required dc=3 hw=%0d", drop_cnt, high_water, DEPTH);
    end
`endif
    n = 0; bad = 0;
    for (int c = 0; c < 2 * DEPTH + 6; c++) begin
      tick(0, 8'h00, 0);
      if (out_valid === 1'b1) begin
        if (n >= DEPTH || out_data !== exp_b[n]) bad = 1;
        n++;
      end
    end
    tests_run++;
    if (n != DEPTH || bad || level !== '0 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_drain: strobes=%0d data_err=%b lvl=%0d ovf=%b, required %0d 0 0 1",
               n, bad, level, overflow, DEPTH);
    end
  endtask

  // Test 4: a write while full on the same edge as a launch.
  task automatic test_full_launch();
    int errs;
    do_reset();
    for (int i = 0; i < DEPTH; i++) tick(1, 8'($urandom), 1);
    tick(1, 8'hEE, 0);
    tests_run++;
    if (level !== LW'(DEPTH - 1) || overflow !== 1'b1 || out_valid !== 1'b1 || out_data !== m_out_data) begin
      fails++;
      $display("FAIL full_launch: lvl=%0d ovf=%b ov=%b od=%h, required lvl=%0d ovf=1 ov=1 od=%h",
               level, overflow, out_valid, out_data, DEPTH - 1, m_out_data);
    end
    errs = 0;
    for (int c = 0; c < 2 * DEPTH + 4; c++) begin
      tick(0, 8'h00, 0);
      if (out_valid !== m_out_valid || out_data !== m_out_data || level !== LW'(m_q.size())) errs++;
    end
    tests_run++;
    if (errs != 0 || level !== '0) begin
      fails++;
      $display("FAIL full_launch_drain: cycle_errs=%0d lvl=%0d, required 0 0", errs, level);
    end
  endtask

  // Test 5: steady state at level 5, with a write on every launch edge, for
  // 3*DEPTH bytes.
  task automatic test_steady_wrap();
    int errs;
    int lvl_errs;
    int sent;
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, 8'($urandom), 1);
    errs = 0; lvl_errs = 0; sent = 0;
    for (int c = 0; c < 6 * DEPTH; c++) begin
      tick((c % 2) == 0, 8'($urandom), 0);
      if (out_valid !== m_out_valid || out_data !== m_out_data) errs++;
      if (level !== LW'(5)) lvl_errs++;
      if (out_valid === 1'b1) sent++;
    end
    tests_run++;
    if (errs != 0 || lvl_errs != 0 || sent != 3 * DEPTH) begin
      fails++;
      $display("FAIL steady_wrap: data_errs=%0d level_errs=%0d strobes=%0d, required 0 0 %0d",
               errs, lvl_errs, sent, 3 * DEPTH);
    end
  endtask

  // Test 6: reset during a drain, in the cycle right after a launch.
  task automatic test_reset_mid_drain();
    bit found;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) tick(1, 8'($urandom), 1);
    found = 0;
    for (int c = 0; c < 4 * DEPTH && !found; c++) begin
      tick(0, 8'h00, 0);
      if (m_q.size() == 10 && m_prev_launch) found = 1;
    end
    tests_run++;
    if (!found || level !== LW'(10) || out_valid !== 1'b1 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL mid_setup: reached=%b lvl=%0d ov=%b ovf=%b, required 1 10 1 1",
               found, level, out_valid, overflow);
    end
    do_reset();
    tests_run++;
    if (level !== '0 || out_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'h0 || high_water !== '0) begin
      fails++;
      $display("FAIL mid_reset: lvl=%0d ov=%b ovf=%b dc=%0d hw=%0d, required all 0",
               level, out_valid, overflow, drop_cnt, high_water);
    end
    tick(0, 8'h00, 0);
    tests_run++;
    if (out_valid !== 1'b0 || level !== '0) begin
      fails++;
      $display("FAIL mid_no_ghost: ov=%b lvl=%0d, required ov=0 lvl=0", out_valid, level);
    end
    tick(1, 8'h5A, 0);
    tick(0, 8'h00, 0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || level !== '0) begin
      fails++;
      $display("FAIL mid_resume: ov=%b od=%h lvl=%0d, required ov=1 od=5a lvl=0", out_valid, out_data, level);
    end
  endtask

  // Random traffic compared against the model on every cycle.
  task automatic test_random();
    int errs;
    int first_bad;
    bit busy;
    do_reset();
    errs = 0; first_bad = -1; busy = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 9) == 0) busy = !busy;
      tick($urandom_range(0, 99) < 60, 8'($urandom), busy);
      if (out_valid !== m_out_valid || out_data !== m_out_data || level !== LW'(m_q.size()) ||
          in_busy !== (m_q.size() == DEPTH) || overflow !== m_ovf ||
          high_water !== LW'(exp_hw()) || drop_cnt !== 16'(exp_drop())) begin
        errs++;
        if (first_bad < 0) first_bad = c;
      end
    end
    tests_run++;
    if (errs != 0) begin
      fails++;
      $display("FAIL random_model: mismatching cycles=%0d first at cycle %0d, required 0", errs, first_bad);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    out_busy = 1'b0;
    test_reset();
    test_single();
    test_burst_line();
    test_overflow();
    test_full_launch();
    test_steady_wrap();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
